// File: rtl/mem_demux_pkg.sv
// Shared types and constants for the data-memory request demultiplexer.
// Target indices also define the bit positions in the one-hot select.
package mem_demux_pkg;

    localparam int NTARGETS = 3;
    localparam int T_RAM    = 0;
    localparam int T_MMIO   = 1;
    localparam int T_TMR    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    // One-hot target select to the binary index expected by mux3.
    function automatic logic [1:0] onehot_to_idx(input logic [NTARGETS-1:0] oh);
        return {oh[T_TMR], oh[T_MMIO]};
    endfunction

endpackage

// File: rtl/mux3.sv
// Three-input data multiplexer; an out-of-range select yields zero.
module mux3 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [1:0]   s,
    output logic [W-1:0] y
);

    always_comb begin
        case (s)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/region_decode.sv
// Combinational decode of a 4-bit address region into a one-hot target
// select and a hit flag.
module region_decode
    import mem_demux_pkg::*;
#(
    parameter logic [3:0] REGION_RAM  = 4'h0,
    parameter logic [3:0] REGION_MMIO = 4'h1,
    parameter logic [3:0] REGION_TMR  = 4'h2
) (
    input  logic [3:0]          region,
    output logic [NTARGETS-1:0] sel,
    output logic                hit
);

    localparam logic [4*NTARGETS-1:0] REGIONS = {REGION_TMR, REGION_MMIO, REGION_RAM};

    for (genvar gi = 0; gi < NTARGETS; gi++) begin : g_match
        assign sel[gi] = (region == REGIONS[gi*4 +: 4]);
    end

    assign hit = |sel;

endmodule

// File: rtl/mem_req_demux.sv
// Routes one outstanding core data-memory request to RAM, MMIO or timer,
// returning a single-cycle response, with unmapped/timeout errors.
module mem_req_demux
    import mem_demux_pkg::*;
#(
    parameter int         WIDTH       = 32,
    parameter int         TIMEOUT     = 16,
    parameter logic [3:0] REGION_RAM  = 4'h0,
    parameter logic [3:0] REGION_MMIO = 4'h1,
    parameter logic [3:0] REGION_TMR  = 4'h2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [WIDTH-1:0]          req_addr,
    input  logic [WIDTH-1:0]          req_wdata,
    input  logic [3:0]                req_wstrb,
    output logic                      resp_valid,
    output logic [WIDTH-1:0]          resp_rdata,
    output logic                      resp_err,
    output logic [NTARGETS-1:0]       t_valid,
    input  logic [NTARGETS-1:0]       t_ready,
    output logic                      t_we,
    output logic [WIDTH-1:0]          t_addr,
    output logic [WIDTH-1:0]          t_wdata,
    output logic [3:0]                t_wstrb,
    input  logic [NTARGETS-1:0]       t_resp_valid,
    input  logic [NTARGETS*WIDTH-1:0] t_rdata
);

    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t                state_reg, state_next;
    logic [NTARGETS-1:0]   sel_reg, sel_next;
    logic                  we_reg, we_next;
    logic [WIDTH-1:0]      addr_reg, addr_next;
    logic [WIDTH-1:0]      wdata_reg, wdata_next;
    logic [3:0]            wstrb_reg, wstrb_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic                  resp_valid_reg, resp_valid_next;
    logic                  resp_err_reg, resp_err_next;
    logic [WIDTH-1:0]      resp_rdata_reg, resp_rdata_next;

    logic [NTARGETS-1:0]   dec_sel;
    logic                  dec_hit;
    logic [WIDTH-1:0]      sel_rdata;
    logic                  tmo;
    logic                  accept;
    logic                  got_resp;
    logic [CW-1:0]         cnt_inc;

    region_decode #(
        .REGION_RAM  (REGION_RAM),
        .REGION_MMIO (REGION_MMIO),
        .REGION_TMR  (REGION_TMR)
    ) u_decode (
        .region (req_addr[WIDTH-1 -: 4]),
        .sel    (dec_sel),
        .hit    (dec_hit)
    );

    mux3 #(.W(WIDTH)) u_rdata_mux (
        .a (t_rdata[T_RAM*WIDTH  +: WIDTH]),
        .b (t_rdata[T_MMIO*WIDTH +: WIDTH]),
        .c (t_rdata[T_TMR*WIDTH  +: WIDTH]),
        .s (onehot_to_idx(sel_reg)),
        .y (sel_rdata)
    );

    assign tmo      = (cnt_reg == TMO_LAST);
    assign accept   = |(t_ready & sel_reg);
    assign got_resp = |(t_resp_valid & sel_reg);
    assign cnt_inc  = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        wstrb_next      = wstrb_reg;
        cnt_next        = cnt_reg;
        resp_valid_next = 1'b0;
        resp_err_next   = 1'b0;
        resp_rdata_next = '0;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    sel_next   = dec_sel;
                    we_next    = req_we;
                    addr_next  = req_addr;
                    wdata_next = req_wdata;
                    wstrb_next = req_wstrb;
                    cnt_next   = '0;
                    state_next = dec_hit ? REQ : ERR;
                end
            end
            // t_valid is already gated off in the timeout cycle, so a
            // t_ready seen then is not an accept.
            REQ: begin
                cnt_next = cnt_inc;
                if (tmo) begin
                    state_next = ERR;
                end else if (accept && got_resp) begin
                    resp_valid_next = 1'b1;
                    resp_rdata_next = we_reg ? '0 : sel_rdata;
                    state_next      = IDLE;
                end else if (accept) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                cnt_next = cnt_inc;
                if (got_resp) begin
                    resp_valid_next = 1'b1;
                    resp_rdata_next = we_reg ? '0 : sel_rdata;
                    state_next      = IDLE;
                end else if (tmo) begin
                    state_next = ERR;
                end
            end
            ERR: begin
                resp_valid_next = 1'b1;
                resp_err_next   = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            sel_reg        <= '0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            cnt_reg        <= '0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            wstrb_reg      <= wstrb_next;
            cnt_reg        <= cnt_next;
            resp_valid_reg <= resp_valid_next;
            resp_err_reg   <= resp_err_next;
            resp_rdata_reg <= resp_rdata_next;
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign t_valid    = (state_reg == REQ && !tmo) ? sel_reg : '0;
    assign t_we       = we_reg;
    assign t_addr     = addr_reg;
    assign t_wdata    = wdata_reg;
    assign t_wstrb    = wstrb_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_mem_req_demux.sv
// Self-checking bench for mem_req_demux: directed scenarios plus randomized
// transactions checked against a cycle-count model of the target protocol.
module tb_mem_req_demux;

    localparam int W  = 32;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic           req_we;
    logic [W-1:0]   req_addr;
    logic [W-1:0]   req_wdata;
    logic [3:0]     req_wstrb;
    logic           resp_valid;
    logic [W-1:0]   resp_rdata;
    logic           resp_err;
    logic [2:0]     t_valid;
    logic [2:0]     t_ready;
    logic           t_we;
    logic [W-1:0]   t_addr;
    logic [W-1:0]   t_wdata;
    logic [3:0]     t_wstrb;
    logic [2:0]     t_resp_valid;
    logic [3*W-1:0] t_rdata;

    int tests = 0;
    int fails = 0;

    mem_req_demux #(
        .WIDTH       (W),
        .TIMEOUT     (TO),
        .REGION_RAM  (4'h0),
        .REGION_MMIO (4'h1),
        .REGION_TMR  (4'h2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .t_valid      (t_valid),
        .t_ready      (t_ready),
        .t_we         (t_we),
        .t_addr       (t_addr),
        .t_wdata      (t_wdata),
        .t_wstrb      (t_wstrb),
        .t_resp_valid (t_resp_valid),
        .t_rdata      (t_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_wstrb    = '0;
        t_ready      = '0;
        t_resp_valid = '0;
        t_rdata      = '0;
    endtask

    // kind 0..2 = target index, 3 = unmapped region. The target accepts in
    // request cycle 1+da and responds dr cycles later (dr=0: same cycle).
    task automatic run_txn(input int kind, input bit we, input int da, input int dr,
                           input logic [W-1:0] data, input string name);
        logic [W-1:0] addr;
        logic [W-1:0] wd;
        logic [3:0]   ws;
        logic [2:0]   oh;
        logic [3:0]   region;
        int           resp_cyc;
        int           resp_cnt;
        int           tv_cnt;
        logic         got_err;
        logic [W-1:0] got_rdata;
        bit           bad_tv;
        int           exp_cyc;
        logic         exp_err;
        logic [W-1:0] exp_rdata;
        int           exp_tv;

        region = (kind < 3) ? 4'(kind) : 4'($urandom_range(3, 15));
        addr   = {region, 28'($urandom)};
        wd     = $urandom;
        ws     = 4'($urandom_range(1, 15));
        oh     = (kind < 3) ? (3'b001 << kind) : 3'b000;

        // Model: request cycles start at 1; a target response is honoured
        // in request cycles 1..TO, otherwise an error shows at cycle TO+2.
        if (kind == 3) begin
            exp_cyc = 2; exp_err = 1'b1; exp_rdata = '0; exp_tv = 0;
        end else if (1 + da <= TO - 1) begin
            exp_tv = da + 1;
            if (1 + da + dr <= TO) begin
                exp_cyc = da + dr + 2; exp_err = 1'b0; exp_rdata = we ? '0 : data;
            end else begin
                exp_cyc = TO + 2; exp_err = 1'b1; exp_rdata = '0;
            end
        end else begin
            exp_tv = TO - 1; exp_cyc = TO + 2; exp_err = 1'b1; exp_rdata = '0;
        end

        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s req_ready: got %b expected 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        step();
        req_valid = 1'b0;

        resp_cyc = -1; resp_cnt = 0; tv_cnt = 0; bad_tv = 0;
        got_err = 1'b0; got_rdata = '0;
        for (int c = 1; c <= TO + 5; c++) begin
            if (resp_valid === 1'b1) begin
                resp_cnt++;
                if (resp_cnt == 1) begin
                    resp_cyc = c; got_err = resp_err; got_rdata = resp_rdata;
                end
            end
            if (t_valid !== 3'b000) begin
                tv_cnt++;
                if (t_valid !== oh || t_addr !== addr || t_we !== we ||
                    t_wdata !== wd || t_wstrb !== ws)
                    bad_tv = 1;
            end
            t_ready      = 3'($urandom) & ~oh;
            t_resp_valid = 3'($urandom) & ~oh;
            t_rdata      = {$urandom, $urandom, $urandom};
            if (kind < 3) begin
                t_rdata[kind*W +: W] = data;
                if (c == 1 + da)      t_ready      = t_ready | oh;
                if (c == 1 + da + dr) t_resp_valid = t_resp_valid | oh;
            end
            step();
        end
        t_ready = '0; t_resp_valid = '0;

        tests++;
        if (resp_cnt != 1 || resp_cyc != exp_cyc) begin
            fails++;
            $display("FAIL %s resp_timing: got %0d pulses first at cycle %0d expected 1 at cycle %0d",
                     name, resp_cnt, resp_cyc, exp_cyc);
        end
        tests++;
        if (got_err !== exp_err || got_rdata !== exp_rdata) begin
            fails++;
            $display("FAIL %s resp_data: got err=%b rdata=%h expected err=%b rdata=%h",
                     name, got_err, got_rdata, exp_err, exp_rdata);
        end
        tests++;
        if (tv_cnt != exp_tv || bad_tv) begin
            fails++;
            $display("FAIL %s t_valid: got %0d cycles (fields_bad=%0d) expected %0d cycles of %b",
                     name, tv_cnt, bad_tv, exp_tv, oh);
        end
        $display("[TB] %s kind=%0d we=%0d da=%0d dr=%0d -> resp@%0d err=%b rdata=%h",
                 name, kind, we, da, dr, resp_cyc, got_err, got_rdata);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b1;
        req_addr = 32'h1234_5678;
        step();
        req_valid = 1'b0;
        step();
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
            resp_rdata !== '0 || t_valid !== 3'b000) begin
            fails++;
            $display("FAIL reset_outputs: got ready=%b rv=%b err=%b rdata=%h tv=%b expected 1 0 0 0 000",
                     req_ready, resp_valid, resp_err, resp_rdata, t_valid);
        end
        tests++;
        if (t_we !== 1'b0 || t_addr !== '0 || t_wdata !== '0 || t_wstrb !== '0) begin
            fails++;
            $display("FAIL reset_fields: got we=%b addr=%h wdata=%h wstrb=%h expected all 0",
                     t_we, t_addr, t_wdata, t_wstrb);
        end
        reset = 1'b0;
        idle_inputs();
        step();
        $display("[TB] reset check done");
    endtask

    task automatic test_directed();
        run_txn(0, 1'b0, 0, 1, 32'hCAFE_0001, "ram_read");
        run_txn(1, 1'b1, 3, 1, 32'h1111_2222, "mmio_write");
        run_txn(3, 1'b0, 0, 0, 32'h0, "unmapped");
        run_txn(2, 1'b0, 0, TO + 2, 32'hDEAD_BEEF, "tmr_timeout");
        run_txn(0, 1'b0, 0, 0, 32'hA5A5_0F0F, "same_cycle");
        run_txn(1, 1'b0, TO - 2, 1, 32'h0BAD_F00D, "resp_at_deadline");
        run_txn(2, 1'b0, TO - 1, 0, 32'h1234_0000, "never_accepted");
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010;
        req_wdata = '0; req_wstrb = 4'hF;
        step();
        req_valid = 1'b0;
        t_ready = 3'b001; t_resp_valid = 3'b001;
        t_rdata = '0; t_rdata[0 +: W] = 32'h1357_9BDF;
        step();
        t_ready = '0; t_resp_valid = '0;
        tests++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b1 || resp_rdata !== 32'h1357_9BDF) begin
            fails++;
            $display("FAIL b2b_first: got rv=%b ready=%b rdata=%h expected 1 1 13579bdf",
                     resp_valid, req_ready, resp_rdata);
        end
        req_valid = 1'b1; req_addr = 32'h1000_0020;
        step();
        req_valid = 1'b0;
        tests++;
        if (t_valid !== 3'b010 || t_addr !== 32'h1000_0020 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second_req: got tv=%b addr=%h rv=%b expected 010 10000020 0",
                     t_valid, t_addr, resp_valid);
        end
        t_ready = 3'b010; t_resp_valid = 3'b010;
        t_rdata[W +: W] = 32'h2468_ACE0;
        step();
        t_ready = '0; t_resp_valid = '0;
        tests++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h2468_ACE0) begin
            fails++;
            $display("FAIL b2b_second_resp: got rv=%b err=%b rdata=%h expected 1 0 2468ace0",
                     resp_valid, resp_err, resp_rdata);
        end
        step();
        $display("[TB] back_to_back done");
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040;
        step();
        req_valid = 1'b0;
        t_ready = 3'b001;
        step();
        t_ready = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if (req_ready !== 1'b1 || t_valid !== 3'b000 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got ready=%b tv=%b rv=%b expected 1 000 0",
                     req_ready, t_valid, resp_valid);
        end
        t_resp_valid = 3'b001; t_rdata[0 +: W] = 32'hFFFF_0000;
        step();
        t_resp_valid = '0;
        step();
        tests++;
        if (resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_late_resp: got rv=%b expected 0", resp_valid);
        end
        $display("[TB] reset_mid done");
        run_txn(0, 1'b0, 1, 2, 32'h7777_8888, "after_reset");
    endtask

    task automatic test_random();
        int kind, da, dr;
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 3);
            case ($urandom_range(0, 5))
                4:       da = TO - 2;
                5:       da = TO - 1;
                default: da = $urandom_range(0, 3);
            endcase
            case ($urandom_range(0, 4))
                3:       dr = TO - 1 - da;
                4:       dr = TO - da;
                default: dr = $urandom_range(0, 3);
            endcase
            if (dr < 0) dr = 0;
            run_txn(kind, 1'($urandom), da, dr, $urandom, "random");
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
